// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time (in clk cycles) of each complete
// cycle of an asynchronous input, with stuck-high / stuck-low timeout detection.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARM      = 2'd1,
    MEAS     = 2'd2
  } state_t;

  localparam int                 FLUSH_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_rise;
  logic                   r_fall;
  logic [FLUSH_W-1:0]     r_flush;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hi;
  logic [CNT_W-1:0]       r_to;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_frozen;
  logic                   r_valid;
  logic                   r_stuck_high;
  logic                   r_stuck_low;

  logic w_s;
  logic w_flushed;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_flushed = (r_flush == FLUSH_LAST);

  // Edge pulses are registered, so r_s_d is the level aligned with r_rise/r_fall.
  // r_flush marks when r_s_d holds a real sample rather than a reset zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_s_d   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_flush <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d;
      r_fall <= ~w_s & r_s_d;
      if (!w_flushed) r_flush <= r_flush + 1'b1;
    end
  end

  // valid is a one-clock strobe; period/high_time hold until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WAIT_LOW;
      r_cnt        <= '0;
      r_hi         <= '0;
      r_to         <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_frozen     <= 1'b0;
      r_valid      <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == WAIT_LOW) begin
        if (w_flushed && !r_s_d) begin
          r_state <= ARM;
          r_to    <= '0;
        end
      end else if (r_rise) begin
        // A rise on the timeout clock wins: publish and skip the stuck flag.
        if (r_state == MEAS) begin
          r_period <= r_cnt;
          r_high   <= r_hi;
          r_valid  <= 1'b1;
        end
        r_cnt        <= CNT_W'(1);
        r_hi         <= CNT_W'(1);
        r_frozen     <= 1'b0;
        r_to         <= '0;
        r_stuck_high <= 1'b0;
        r_stuck_low  <= 1'b0;
        r_state      <= MEAS;
      end else if (r_to == TO_LAST) begin
        r_to <= '0;
        if (r_s_d) begin
          r_stuck_high <= 1'b1;
          r_state      <= WAIT_LOW;
        end else begin
          r_stuck_low <= 1'b1;
          r_state     <= ARM;
        end
      end else begin
        r_to <= r_to + 1'b1;
        if (r_state == MEAS) begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (r_fall) r_frozen <= 1'b1;
          else if (r_s_d && !r_frozen && (r_hi != CNT_MAX)) r_hi <= r_hi + 1'b1;
        end
      end
    end
  end

  assign period     = r_period;
  assign high_time  = r_high;
  assign valid      = r_valid;
  assign stuck_high = r_stuck_high;
  assign stuck_low  = r_stuck_low;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: scenario tasks drive waveforms one sample per clock and
// push expected (period, high_time) pairs; a negedge monitor pops and compares.
module tb_pwm_capture;
  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int TO    = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stuck_high;
  logic             stuck_low;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .period(period), .high_time(high_time),
    .valid(valid), .stuck_high(stuck_high), .stuck_low(stuck_low), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;
  logic have_prev = 1'b0;
  int   prev_n = 0;
  int   prev_h = 0;
  logic [2*CNT_W-1:0] exp_q[$];

  // Scoreboard monitor
  initial begin : monitor
    logic [CNT_W-1:0] e_p, e_h;
    forever begin
      @(negedge clk);
      if (!rst && valid) begin
        n_valid++;
        n_cmp++;
        if (prev_valid) begin
          n_err++;
          $display("FAIL valid_width: valid high on consecutive clocks at cyc %0d, required 1-clock strobe", cyc);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: period=%0d high_time=%0d at cyc %0d, required no valid", period, high_time, cyc);
        end else begin
          {e_p, e_h} = exp_q.pop_front();
          if (period !== e_p) begin
            n_err++;
            $display("FAIL meas_period: got %0d required %0d", period, e_p);
          end
          n_cmp++;
          if (high_time !== e_h) begin
            n_err++;
            $display("FAIL meas_high_time: got %0d required %0d", high_time, e_h);
          end
        end
      end
      prev_valid = valid & !rst;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive_level(input logic b);
    @(negedge clk);
    pwm_in = b;
  endtask

  task automatic drive_cycles(input int n, input int h, input int reps);
    for (int r = 0; r < reps; r++) begin
      if (have_prev) exp_q.push_back({CNT_W'(prev_n), CNT_W'(prev_h)});
      have_prev = 1'b1;
      prev_n = n;
      prev_h = h;
      for (int i = 0; i < n; i++) drive_level(i < h);
    end
  endtask

  task automatic apply_reset(input logic lvl);
    @(negedge clk);
    rst = 1'b1;
    pwm_in = lvl;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    have_prev = 1'b0;
    exp_q.delete();
    n_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({period, high_time, valid, stuck_high, stuck_low} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got p=%0d h=%0d v=%b sh=%b sl=%b, required all 0",
               period, high_time, valid, stuck_high, stuck_low);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int r2;
    apply_reset(1'b0);
    repeat (8) drive_level(1'b0);
    drive_cycles(10, 3, 1);
    exp_q.push_back({CNT_W'(10), CNT_W'(3)});
    drive_level(1'b1);
    r2 = cyc;
    drive_level(1'b1);
    drive_level(1'b1);
    drive_level(1'b0);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: valid=%b at %0d clks after 2nd rise, required 0", valid, cyc - r2);
    end
    drive_level(1'b0);
    n_cmp++;
    if (valid !== 1'b1) begin
      n_err++;
      $display("FAIL latency: valid=%b at %0d clks after 2nd rise, required 1", valid, cyc - r2);
    end
    repeat (5) drive_level(1'b0);
    have_prev = 1'b1;
    prev_n = 10;
    prev_h = 3;
    drive_cycles(10, 3, 3);
    repeat (10) drive_level(1'b0);
    n_cmp++;
    if (n_valid !== 4) begin
      n_err++;
      $display("FAIL basic_count: got %0d valids required 4", n_valid);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL basic_drain: %0d expected results never produced, required 0", exp_q.size());
    end
  endtask

  task automatic test_duty_step;
    apply_reset(1'b0);
    repeat (8) drive_level(1'b0);
    drive_cycles(10, 3, 3);
    drive_cycles(10, 7, 3);
    repeat (10) drive_level(1'b0);
    n_cmp++;
    if (n_valid !== 5 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL duty_count: got %0d valids (%0d pending) required 5 (0 pending)", n_valid, exp_q.size());
    end
    n_cmp++;
    if (period !== CNT_W'(10) || high_time !== CNT_W'(7)) begin
      n_err++;
      $display("FAIL duty_hold: got p=%0d h=%0d required p=10 h=7", period, high_time);
    end
  endtask

  task automatic test_high_at_reset;
    apply_reset(1'b1);
    repeat (10) drive_level(1'b1);
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL high_reset_state: got %0d required 0 (WAIT_LOW)", dbg_state);
    end
    repeat (3) drive_level(1'b0);
    drive_cycles(4, 1, 5);
    drive_cycles(2, 1, 4);
    repeat (8) drive_level(1'b0);
    n_cmp++;
    if (n_valid !== 8 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL high_reset_count: got %0d valids (%0d pending) required 8 (0 pending)", n_valid, exp_q.size());
    end
  endtask

  task automatic test_stuck_high;
    int rc;
    apply_reset(1'b0);
    repeat (8) drive_level(1'b0);
    drive_cycles(6, 2, 3);
    exp_q.push_back({CNT_W'(6), CNT_W'(2)});
    have_prev = 1'b0;
    drive_level(1'b1);
    rc = cyc;
    repeat (103) drive_level(1'b1);
    n_cmp++;
    if (stuck_high !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_high_early: got %b at rise+%0d required 0", stuck_high, cyc - rc - SYNC - 2);
    end
    drive_level(1'b1);
    n_cmp++;
    if (stuck_high !== 1'b1 || stuck_low !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL stuck_high_set: got sh=%b sl=%b st=%0d required sh=1 sl=0 st=0", stuck_high, stuck_low, dbg_state);
    end
    n_cmp++;
    if (period !== CNT_W'(6) || high_time !== CNT_W'(2)) begin
      n_err++;
      $display("FAIL stuck_high_hold: got p=%0d h=%0d required p=6 h=2", period, high_time);
    end
    repeat (20) drive_level(1'b1);
    repeat (4) drive_level(1'b0);
    drive_level(1'b1);
    rc = cyc;
    drive_level(1'b1);
    drive_level(1'b1);
    drive_level(1'b0);
    n_cmp++;
    if (stuck_high !== 1'b1) begin
      n_err++;
      $display("FAIL stuck_high_hold_flag: got %b before rise reached FSM, required 1", stuck_high);
    end
    drive_level(1'b0);
    n_cmp++;
    if (stuck_high !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_high_clear: got %b required 0", stuck_high);
    end
    repeat (5) drive_level(1'b0);
    have_prev = 1'b1;
    prev_n = 10;
    prev_h = 3;
    drive_cycles(10, 3, 1);
    repeat (8) drive_level(1'b0);
    n_cmp++;
    if (n_valid !== 4 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL stuck_high_count: got %0d valids (%0d pending) required 4 (0 pending)", n_valid, exp_q.size());
    end
  endtask

  task automatic test_stuck_low;
    int rc;
    int ra;
    apply_reset(1'b0);
    repeat (8) drive_level(1'b0);
    drive_cycles(8, 3, 1);
    exp_q.push_back({CNT_W'(8), CNT_W'(3)});
    have_prev = 1'b0;
    drive_level(1'b1);
    rc = cyc;
    drive_level(1'b1);
    drive_level(1'b1);
    repeat (101) drive_level(1'b0);
    n_cmp++;
    if (stuck_low !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_low_early: got %b required 0", stuck_low);
    end
    drive_level(1'b0);
    n_cmp++;
    if (stuck_low !== 1'b1 || stuck_high !== 1'b0 || dbg_state !== 2'd1) begin
      n_err++;
      $display("FAIL stuck_low_set: got sl=%b sh=%b st=%0d required sl=1 sh=0 st=1", stuck_low, stuck_high, dbg_state);
    end
    n_cmp++;
    if (period !== CNT_W'(8) || high_time !== CNT_W'(3)) begin
      n_err++;
      $display("FAIL stuck_low_hold: got p=%0d h=%0d required p=8 h=3", period, high_time);
    end
    repeat (5) drive_level(1'b0);
    drive_level(1'b1);
    ra = cyc;
    repeat (4) drive_level(1'b1);
    n_cmp++;
    if (stuck_low !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_low_clear: got %b required 0", stuck_low);
    end
    repeat (95) drive_level(1'b0);
    exp_q.push_back({CNT_W'(100), CNT_W'(5)});
    drive_level(1'b1);
    repeat (3) drive_level(1'b1);
    drive_level(1'b0);
    n_cmp++;
    if (valid !== 1'b1 || stuck_low !== 1'b0 || stuck_high !== 1'b0) begin
      n_err++;
      $display("FAIL rise_at_timeout: got v=%b sl=%b sh=%b at cyc %0d after arm, required v=1 sl=0 sh=0",
               valid, stuck_low, stuck_high, cyc - ra);
    end
    repeat (10) drive_level(1'b0);
    n_cmp++;
    if (n_valid !== 2 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL stuck_low_count: got %0d valids (%0d pending) required 2 (0 pending)", n_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    apply_reset(1'b0);
    repeat (8) drive_level(1'b0);
    drive_cycles(10, 3, 3);
    exp_q.push_back({CNT_W'(10), CNT_W'(3)});
    have_prev = 1'b0;
    repeat (3) drive_level(1'b1);
    repeat (5) drive_level(1'b0);
    n_cmp++;
    if (n_valid !== 3 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL pre_reset_count: got %0d valids (%0d pending) required 3 (0 pending)", n_valid, exp_q.size());
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({period, high_time, valid, stuck_high, stuck_low, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got p=%0d h=%0d v=%b sh=%b sl=%b st=%0d required all 0",
               period, high_time, valid, stuck_high, stuck_low, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_valid = 0;
    repeat (4) drive_level(1'b0);
    drive_cycles(10, 3, 3);
    repeat (10) drive_level(1'b0);
    n_cmp++;
    if (n_valid !== 2 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL rearm_count: got %0d valids (%0d pending) required 2 (0 pending)", n_valid, exp_q.size());
    end
  endtask

  initial begin : main
    rst = 1'b1;
    pwm_in = 1'b0;
    test_reset();
    test_basic();
    test_duty_step();
    test_high_at_reset();
    test_stuck_high();
    test_stuck_low();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an external PWM waveform, such as the power-LED drive line or a fan tach or servo input, on the system clock. It reports the period and high time of each complete cycle as cycle counts, with a one-cycle valid strobe. It is the receive-side counterpart of the LED PWM generator and is used for loopback checks of that generator and for reading PWM-coded sensors. It detects a stuck-high or stuck-low line by timeout.

Parameters:
CNT_W, 16, width of the period and high_time counters and outputs.
SYNC_STAGES, 2, number of synchronizer flops on pwm_in (minimum 2).
TIMEOUT, 65535, cycles without a qualifying edge before declaring the line stuck (must be less than 2^CNT_W).

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  reset; asynchronous, active-high.
pwm_in  input  1  asynchronous PWM input.
period  output  CNT_W  clocks from one rising edge to the next, for the last complete cycle.
high_time  output  CNT_W  synchronized-high clocks within that cycle.
valid  output  1  one-cycle strobe when period and high_time update.
stuck_high  output  1  line held high for TIMEOUT clocks.
stuck_low  output  1  line held low for TIMEOUT clocks.

Behaviour:
- Reset (asynchronous): synchronizer flops, edge-history flop, counters, period, high_time, valid, stuck_high and stuck_low all go to 0. State goes to WAIT_LOW.
- Synchronizer: pwm_in passes through a SYNC_STAGES-flop chain; s is the last stage and s_d is s delayed by one clock.
  - rise = s and not s_d.
  - fall = not s and s_d.
- States and transitions:
  - WAIT_LOW: ignore rise until s = 0 has been seen, then go to ARM. This prevents a high line at reset release from producing a false edge.
  - ARM: on rise, set cnt = 1 and hi = 1, then go to MEAS. The first edge only arms; valid is not asserted.
  - MEAS, per clock:
    - cnt increments.
    - hi increments while s = 1.
    - On fall, hi freezes.
    - On rise: period <= cnt, high_time <= hi, valid <= 1 on the next clock, restart cnt = 1 and hi = 1, stay in MEAS.
- Measured values: for a steady input with a high time of H clocks and a period of N clocks, the block reports period = N and high_time = H. Minimum measurable values are N = 2 and H = 1.
- Latency: valid rises SYNC_STAGES + 1 clocks after the first clk edge that samples the second rising edge of pwm_in high. period and high_time are stable at least from valid until the next valid.
- valid is high for exactly 1 clock per measured cycle. It is never asserted for the arming edge or after a timeout.
- Timeout: in ARM or MEAS, if TIMEOUT clocks pass without a rise:
  - set stuck_high if s = 1, otherwise set stuck_low;
  - go to WAIT_LOW if s = 1, otherwise go to ARM;
  - the partial measurement is discarded; period and high_time hold their last values.
- Stuck flags are level outputs and clear on the next rise.
- Counters saturate at 2^CNT_W - 1 and never wrap. Timeout always fires first because of the TIMEOUT constraint.
- Simultaneous timeout and rise on the same clock: rise wins, the measurement is published, and no stuck flag is set.
- Reset mid-measurement: everything clears; the next valid requires a low sample, then an arming rise, then a full cycle.

Test Plan:
- PWM period 10 clks, high 3 clks, 5 cycles -> exactly 4 valid pulses, each with period=10 and high_time=3; each valid 1 clk wide; first valid SYNC_STAGES+1 clks after the second rise is sampled.
- Duty steps from high 3/period 10 to high 7/period 10 mid-stream -> the cycle straddling the change reports the correct mixed values; subsequent valids report period=10, high_time=7.
- pwm_in held high at reset release, then toggled with period 4, high 1 -> no valid until after a low, the arming rise and one full cycle; then period=4, high_time=1.
- TIMEOUT=100, input stuck high after one arming rise -> stuck_high=1 at clock 100 after the rise, no valid, period and high_time unchanged; resuming PWM clears stuck_high on the first rise, and valid follows one cycle later.
- TIMEOUT=100, input stuck low -> stuck_low asserts and the block rearms in ARM; with a rise arriving on exactly the timeout clock -> valid, no flag.
- Assert rst mid-MEAS -> all outputs 0 immediately (asynchronous); no valid until the full re-arm sequence completes.
